// File: rtl/bp_me_pkg.sv
// bp_me_pkg: shared constants and error encoding for the BedRock memory-command mux.
package bp_me_pkg;

   localparam int mux_default_depth_gp = 8;

   // First protocol violation seen since reset; error_o is any non-none value.
   typedef enum logic [1:0] {
      mux_err_none_e       = 2'd0,
      mux_err_empty_resp_e = 2'd1,
      mux_err_bad_yumi_e   = 2'd2
   } mux_err_e;

endpackage

// File: rtl/bp_me_mem_cmd_mux_rr_arb.sv
// bp_me_mem_cmd_mux_rr_arb: round-robin arbiter; the pointer moves to the grant only on a transfer.
module bp_me_mem_cmd_mux_rr_arb
   import bp_me_pkg::*;
#(
   parameter int num_clients_p = 4,
   localparam int lg_clients_lp = (num_clients_p > 1) ? $clog2(num_clients_p) : 1
)
(
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [num_clients_p-1:0] v_i,
   input  logic                     yumi_i,
   output logic [num_clients_p-1:0] grant_oh_o,
   output logic [lg_clients_lp-1:0] grant_id_o,
   output logic                     v_o
);

   logic [lg_clients_lp-1:0] ptr_q, ptr_d;

   function automatic logic [lg_clients_lp-1:0] wrap_add(input logic [lg_clients_lp-1:0] p, input int i);
      return lg_clients_lp'((int'(p) + i) % num_clients_p);
   endfunction

   // Scan downward so the nearest client after the pointer wins.
   always_comb begin
      grant_id_o = '0;
      for (int i = num_clients_p; i >= 1; i--)
         if (v_i[wrap_add(ptr_q, i)]) grant_id_o = wrap_add(ptr_q, i);
      v_o = |v_i;
      grant_oh_o = v_o ? (num_clients_p'(1) << grant_id_o) : '0;
      ptr_d = yumi_i ? grant_id_o : ptr_q;
   end

   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) ptr_q <= lg_clients_lp'(num_clients_p - 1);
      else ptr_q <= ptr_d;

endmodule

// File: rtl/bp_me_mem_cmd_mux.sv
// bp_me_mem_cmd_mux: N-to-1 BedRock mem_cmd mux with in-order response routing via a source-ID FIFO.
// Optional per-client counters and outstanding high-water mark under BP_ME_MEM_CMD_MUX_STATS_EN.
module bp_me_mem_cmd_mux
   import bp_me_pkg::*;
#(
   parameter int num_clients_p = 4,
   parameter int msg_width_p = 128,
   parameter int max_outstanding_p = mux_default_depth_gp,
   localparam int lg_clients_lp = (num_clients_p > 1) ? $clog2(num_clients_p) : 1,
   localparam int cnt_width_lp = $clog2(max_outstanding_p + 1),
   localparam int ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1
)
(
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic [num_clients_p*msg_width_p-1:0] client_cmd_i,
   input  logic [num_clients_p-1:0]             client_cmd_v_i,
   output logic [num_clients_p-1:0]             client_cmd_ready_o,
   output logic [msg_width_p-1:0]               client_resp_o,
   output logic [num_clients_p-1:0]             client_resp_v_o,
   input  logic [num_clients_p-1:0]             client_resp_yumi_i,
   output logic [msg_width_p-1:0]               mem_cmd_o,
   output logic                                 mem_cmd_v_o,
   input  logic                                 mem_cmd_ready_i,
   input  logic [msg_width_p-1:0]               mem_resp_i,
   input  logic                                 mem_resp_v_i,
   output logic                                 mem_resp_yumi_o,
   output logic [cnt_width_lp-1:0]              outstanding_o,
   output logic                                 error_o
`ifdef BP_ME_MEM_CMD_MUX_STATS_EN
   ,
   output logic [num_clients_p*32-1:0]          cmd_count_o,
   output logic [cnt_width_lp-1:0]              hwm_o
`endif
);

   logic [lg_clients_lp-1:0] fifo_mem_q [max_outstanding_p];
   logic [ptr_width_lp-1:0]  rptr_q, rptr_d, wptr_q, wptr_d;
   logic [cnt_width_lp-1:0]  count_q, count_d;
   logic [lg_clients_lp-1:0] grant_id, head;
   logic [num_clients_p-1:0] grant_oh;
   logic                     arb_v, full, empty, enq, deq, err_empty, err_yumi;
   mux_err_e                 err_q, err_d;

   function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
      return (p == ptr_width_lp'(max_outstanding_p - 1)) ? '0 : p + 1'b1;
   endfunction

   bp_me_mem_cmd_mux_rr_arb #(.num_clients_p(num_clients_p)) arb (
      .clk_i(clk_i),
      .reset_i(reset_i),
      .v_i(client_cmd_v_i),
      .yumi_i(enq),
      .grant_oh_o(grant_oh),
      .grant_id_o(grant_id),
      .v_o(arb_v)
   );

   assign full = count_q == cnt_width_lp'(max_outstanding_p);
   assign empty = count_q == '0;
   assign head = fifo_mem_q[rptr_q];

   assign mem_cmd_o = client_cmd_i[grant_id*msg_width_p +: msg_width_p];
   assign mem_cmd_v_o = arb_v & ~full & ~reset_i;
   assign client_cmd_ready_o = (mem_cmd_ready_i & ~full & ~reset_i) ? grant_oh : '0;
   assign enq = mem_cmd_v_o & mem_cmd_ready_i;

   assign client_resp_o = mem_resp_i;
   assign client_resp_v_o = (mem_resp_v_i & ~empty & ~reset_i) ? (num_clients_p'(1) << head) : '0;
   assign deq = client_resp_yumi_i[head] & client_resp_v_o[head];
   assign mem_resp_yumi_o = deq;

   assign err_empty = mem_resp_v_i & empty;
   assign err_yumi = |(client_resp_yumi_i & ~client_resp_v_o);
   assign outstanding_o = count_q;
   assign error_o = err_q != mux_err_none_e;

   always_comb begin
      rptr_d = deq ? next_ptr(rptr_q) : rptr_q;
      wptr_d = enq ? next_ptr(wptr_q) : wptr_q;
      count_d = (enq & ~deq) ? count_q + 1'b1 : (deq & ~enq) ? count_q - 1'b1 : count_q;
      err_d = (err_q != mux_err_none_e) ? err_q
            : err_empty ? mux_err_empty_resp_e
            : err_yumi ? mux_err_bad_yumi_e : mux_err_none_e;
   end

   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         rptr_q <= '0;
         wptr_q <= '0;
         count_q <= '0;
         err_q <= mux_err_none_e;
      end else begin
         rptr_q <= rptr_d;
         wptr_q <= wptr_d;
         count_q <= count_d;
         err_q <= err_d;
      end

   // Payload storage needs no reset: entries are only read while count_q is nonzero.
   always_ff @(posedge clk_i)
      if (enq) fifo_mem_q[wptr_q] <= grant_id;

`ifdef BP_ME_MEM_CMD_MUX_STATS_EN
   logic [num_clients_p-1:0][31:0] cmd_count_q;
   logic [cnt_width_lp-1:0]        hwm_q;

   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         cmd_count_q <= '0;
         hwm_q <= '0;
      end else begin
         for (int k = 0; k < num_clients_p; k++)
            if (enq && grant_id == lg_clients_lp'(k) && cmd_count_q[k] != 32'hFFFF_FFFF)
               cmd_count_q[k] <= cmd_count_q[k] + 32'd1;
         hwm_q <= (count_d > hwm_q) ? count_d : hwm_q;
      end

   assign cmd_count_o = cmd_count_q;
   assign hwm_o = hwm_q;
`endif

endmodule

// File: tb/tb_bp_me_mem_cmd_mux.sv
// tb_bp_me_mem_cmd_mux: directed bench with a queue-based reference model checked every cycle.
module tb_bp_me_mem_cmd_mux;

   localparam int N = 4;
   localparam int W = 128;
   localparam int D = 4;
   localparam int CW = $clog2(D + 1);

   logic clk = 1'b0;
   logic reset_i;
   logic [N*W-1:0] client_cmd_i;
   logic [N-1:0] client_cmd_v_i, client_cmd_ready_o, client_resp_v_o, client_resp_yumi_i;
   logic [W-1:0] client_resp_o, mem_cmd_o, mem_resp_i;
   logic mem_cmd_v_o, mem_cmd_ready_i, mem_resp_v_i, mem_resp_yumi_o, error_o;
   logic [CW-1:0] outstanding_o;
`ifdef BP_ME_MEM_CMD_MUX_STATS_EN
   logic [N*32-1:0] cmd_count_o;
   logic [CW-1:0] hwm_o;
`endif

   bp_me_mem_cmd_mux #(.num_clients_p(N), .msg_width_p(W), .max_outstanding_p(D)) dut (
      .clk_i(clk),
      .reset_i(reset_i),
      .client_cmd_i(client_cmd_i),
      .client_cmd_v_i(client_cmd_v_i),
      .client_cmd_ready_o(client_cmd_ready_o),
      .client_resp_o(client_resp_o),
      .client_resp_v_o(client_resp_v_o),
      .client_resp_yumi_i(client_resp_yumi_i),
      .mem_cmd_o(mem_cmd_o),
      .mem_cmd_v_o(mem_cmd_v_o),
      .mem_cmd_ready_i(mem_cmd_ready_i),
      .mem_resp_i(mem_resp_i),
      .mem_resp_v_i(mem_resp_v_i),
      .mem_resp_yumi_o(mem_resp_yumi_o),
      .outstanding_o(outstanding_o),
      .error_o(error_o)
`ifdef BP_ME_MEM_CMD_MUX_STATS_EN
      ,
      .cmd_count_o(cmd_count_o),
      .hwm_o(hwm_o)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int seq = 0;

   // Reference model: source IDs in flight, last served client, sticky error.
   int q[$];
   int dut_log[$];
   int lastp = N - 1;
   bit err_m = 1'b0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int exp_grant();
      for (int i = 1; i <= N; i++)
         if (client_cmd_v_i[(lastp + i) % N]) return (lastp + i) % N;
      return -1;
   endfunction

   always @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         q.delete();
         lastp = N - 1;
         err_m = 1'b0;
      end else begin
         int g;
         bit pop, xfer;
         g = exp_grant();
         pop = mem_resp_v_i && q.size() > 0 && client_resp_yumi_i[q[0]];
         if (mem_resp_v_i && q.size() == 0) err_m = 1'b1;
         for (int k = 0; k < N; k++)
            if (client_resp_yumi_i[k] && !(mem_resp_v_i && q.size() > 0 && q[0] == k)) err_m = 1'b1;
         xfer = g >= 0 && q.size() < D && mem_cmd_ready_i;
         if (pop) void'(q.pop_front());
         if (xfer) begin
            q.push_back(g);
            lastp = g;
         end
      end
   end

   always @(negedge clk) begin
      int g;
      logic [N-1:0] e_rdy, e_rv;
      bit can;
      g = exp_grant();
      can = !reset_i && g >= 0 && q.size() < D;
      e_rdy = (can && mem_cmd_ready_i) ? N'(1) << g : '0;
      e_rv = (!reset_i && mem_resp_v_i && q.size() > 0) ? N'(1) << q[0] : '0;
      chk("mem_cmd_v", W'(mem_cmd_v_o), W'(can));
      chk("cmd_ready", W'(client_cmd_ready_o), W'(e_rdy));
      if (g >= 0) chk("mem_cmd", mem_cmd_o, client_cmd_i[g*W +: W]);
      chk("resp_v", W'(client_resp_v_o), W'(e_rv));
      chk("resp_yumi", W'(mem_resp_yumi_o), W'(|(e_rv & client_resp_yumi_i)));
      chk("resp_data", client_resp_o, mem_resp_i);
      chk("outstanding", W'(outstanding_o), W'(q.size()));
      chk("error", W'(error_o), W'(err_m));
      if (!reset_i)
         for (int k = 0; k < N; k++)
            if (client_cmd_ready_o[k] && client_cmd_v_i[k]) dut_log.push_back(k);
   end

   task automatic set_in(input logic [N-1:0] v, input logic rdy, input logic rv, input logic [N-1:0] y);
      client_cmd_v_i = v;
      mem_cmd_ready_i = rdy;
      mem_resp_v_i = rv;
      client_resp_yumi_i = y;
      mem_resp_i = {32'hBEEF_0000 + 32'(seq), 96'h0123_4567_89AB_CDEF_0F0F_F0F0};
      seq++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic [N-1:0] v, input logic rdy, input logic rv, input logic [N-1:0] y);
      set_in(v, rdy, rv, y);
      step();
   endtask

   task automatic pulse_reset();
      reset_i = 1'b1;
      cyc('0, 1'b0, 1'b0, '0);
      reset_i = 1'b0;
   endtask

   task automatic chk_log(input string name, input int exp[$]);
      chk({name, "_len"}, W'(dut_log.size()), W'(exp.size()));
      for (int i = 0; i < exp.size() && i < dut_log.size(); i++) chk(name, W'(dut_log[i]), W'(exp[i]));
      dut_log.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int k = 0; k < N; k++)
         client_cmd_i[k*W +: W] = {64'hC0DE_0000_0000_0000 + 64'(k), 64'(k * 17 + 5)};
      reset_i = 1'b1;
      set_in(4'hF, 1'b1, 1'b0, '0);
      @(negedge clk);
      chk("rst_cmd_v", W'(mem_cmd_v_o), '0);
      chk("rst_ready", W'(client_cmd_ready_o), '0);
      chk("rst_outstanding", W'(outstanding_o), '0);
      chk("rst_error", W'(error_o), '0);
      step();
      reset_i = 1'b0;
      dut_log.delete();

      // All four valid: grants 0,1,2,3 then FIFO full.
      repeat (4) cyc(4'hF, 1'b1, 1'b0, '0);
      set_in(4'hF, 1'b1, 1'b0, '0);
      @(negedge clk);
      chk("full_outstanding", W'(outstanding_o), W'(4));
      chk("full_ready", W'(client_cmd_ready_o), '0);
      chk("full_cmd_v", W'(mem_cmd_v_o), '0);
      step();
      set_in(4'hF, 1'b1, 1'b1, 4'b0001);
      @(negedge clk);
      chk("full_resp_v", W'(client_resp_v_o), W'(4'b0001));
      chk("full_resp_yumi", W'(mem_resp_yumi_o), W'(1));
      chk("full_deq_ready", W'(client_cmd_ready_o), '0);
      step();
      cyc(4'hF, 1'b1, 1'b1, 4'b0010);
      cyc('0, 1'b1, 1'b1, 4'b0100);
      cyc('0, 1'b1, 1'b1, 4'b1000);
      cyc('0, 1'b1, 1'b1, 4'b0001);
      set_in('0, 1'b1, 1'b0, '0);
      @(negedge clk);
      chk("t1_drained", W'(outstanding_o), '0);
      chk("t1_error", W'(error_o), '0);
      chk_log("t1_order", '{0, 1, 2, 3, 0});
      step();

      // Client 2 alone.
      repeat (3) cyc(4'b0100, 1'b1, 1'b0, '0);
      repeat (3) begin
         set_in('0, 1'b1, 1'b1, 4'b0100);
         @(negedge clk);
         chk("t2_resp_v", W'(client_resp_v_o), W'(4'b0100));
         step();
      end
      set_in('0, 1'b1, 1'b0, '0);
      @(negedge clk);
      chk("t2_drained", W'(outstanding_o), '0);
      chk_log("t2_order", '{2, 2, 2});
      step();

      // Clients 1,3,1 with an out-of-turn yumi from 3.
      cyc(4'b0010, 1'b1, 1'b0, '0);
      cyc(4'b1000, 1'b1, 1'b0, '0);
      cyc(4'b0010, 1'b1, 1'b0, '0);
      set_in('0, 1'b1, 1'b1, 4'b1000);
      @(negedge clk);
      chk("t3_bad_yumi", W'(mem_resp_yumi_o), '0);
      chk("t3_head", W'(client_resp_v_o), W'(4'b0010));
      step();
      set_in('0, 1'b1, 1'b1, 4'b0010);
      @(negedge clk);
      chk("t3_error", W'(error_o), W'(1));
      chk("t3_hold", W'(outstanding_o), W'(3));
      step();
      set_in('0, 1'b1, 1'b1, 4'b1000);
      @(negedge clk);
      chk("t3_resp_v3", W'(client_resp_v_o), W'(4'b1000));
      step();
      set_in('0, 1'b1, 1'b1, 4'b0010);
      @(negedge clk);
      chk("t3_resp_v1", W'(client_resp_v_o), W'(4'b0010));
      step();
      chk_log("t3_order", '{1, 3, 1});

      // Response with nothing outstanding.
      pulse_reset();
      set_in('0, 1'b1, 1'b1, '0);
      @(negedge clk);
      chk("t4_clear_error", W'(error_o), '0);
      chk("t4_no_yumi", W'(mem_resp_yumi_o), '0);
      step();
      repeat (3) begin
         set_in('0, 1'b1, 1'b0, '0);
         @(negedge clk);
         chk("t4_sticky", W'(error_o), W'(1));
         step();
      end

      // Downstream stall with clients 0 and 1 waiting.
      pulse_reset();
      dut_log.delete();
      repeat (5) begin
         set_in(4'b0011, 1'b0, 1'b0, '0);
         @(negedge clk);
         chk("t5_stall_v", W'(mem_cmd_v_o), W'(1));
         chk("t5_stall_cmd", mem_cmd_o, {64'hC0DE_0000_0000_0000, 64'd5});
         step();
      end
      set_in(4'b0011, 1'b1, 1'b0, '0);
      @(negedge clk);
      chk("t5_first", W'(client_cmd_ready_o), W'(4'b0001));
      step();
      set_in(4'b0011, 1'b1, 1'b0, '0);
      @(negedge clk);
      chk("t5_second", W'(client_cmd_ready_o), W'(4'b0010));
      step();
      cyc('0, 1'b1, 1'b1, 4'b0001);
      cyc('0, 1'b1, 1'b1, 4'b0010);
      chk_log("t5_order", '{0, 1});

      // Asynchronous reset with three commands in flight.
      repeat (3) cyc(4'b0111, 1'b1, 1'b0, '0);
      set_in(4'hF, 1'b0, 1'b1, '0);
      @(negedge clk);
      chk("t6_pre_outstanding", W'(outstanding_o), W'(3));
      @(posedge clk);
      #2;
      reset_i = 1'b1;
      #1;
      chk("t6_async_outstanding", W'(outstanding_o), '0);
      chk("t6_async_cmd_v", W'(mem_cmd_v_o), '0);
      chk("t6_async_resp_v", W'(client_resp_v_o), '0);
      step();
      reset_i = 1'b0;
      set_in(4'hF, 1'b1, 1'b0, '0);
      @(negedge clk);
      chk("t6_next_grant", W'(client_cmd_ready_o), W'(4'b0001));
      step();
      cyc('0, 1'b1, 1'b0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
